// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble steering, run/stop FSM, saturating hazard counters.
// Optional debug single-step (PAUSE state) is built when PIPE_CTRL_STEP_EN is defined.

module pipe_ctrl_satcnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             step_mode,
    input  logic             step_pulse,
    output logic             F_stall,
    output logic             D_stall,
    output logic             E_stall,
    output logic             M_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [3:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt
);
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_HLT    = 4'h2;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] S_INS    = 4'h4;
    localparam int NCNT = 3;

    typedef enum logic [1:0] {RUN, PAUSE, STOPPED} state_t;
    state_t state;

    logic loaduse, mispred, ret_h, exc, m_exc, w_exc;
    logic advance, run_out;

    assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mispred = (E_icode == I_JXX) && !e_Cnd;
    assign ret_h   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign m_exc   = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign w_exc   = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    assign exc     = m_exc || w_exc;

`ifdef PIPE_CTRL_STEP_EN
    assign advance = (state == RUN) || ((state == PAUSE) && step_pulse);
`else
    assign advance = (state == RUN);
    logic unused_step;
    assign unused_step = step_mode ^ step_pulse;
`endif

    // The reset cycle drives RUN controls regardless of the state being left.
    assign run_out = advance || rst;

    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_stall  = 1'b1;
        M_stall  = 1'b1;
        W_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        if (run_out) begin
            F_stall  = loaduse || ret_h;
            D_stall  = loaduse;
            E_stall  = 1'b0;
            M_stall  = 1'b0;
            W_stall  = (W_stat != S_AOK);
            // loaduse stalls D, so a pending ret must not also bubble it
            D_bubble = mispred || (ret_h && !loaduse);
            E_bubble = mispred || loaduse;
            M_bubble = exc;
            set_cc   = (E_icode == I_OPQ) && !exc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cpu_stat <= S_AOK;
            halted   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (W_stat != S_AOK) begin
                        state    <= STOPPED;
                        cpu_stat <= W_stat;
                        halted   <= 1'b1;
                    end
`ifdef PIPE_CTRL_STEP_EN
                    else if (step_mode)
                        state <= PAUSE;
`endif
                end
                PAUSE: begin
                    if (step_pulse && (W_stat != S_AOK)) begin
                        state    <= STOPPED;
                        cpu_stat <= W_stat;
                        halted   <= 1'b1;
                    end else if (!step_mode)
                        state <= RUN;
                end
                STOPPED: state <= STOPPED;
                default: state <= RUN;
            endcase
        end
    end

    logic [NCNT-1:0]            cnt_inc;
    logic [NCNT-1:0][CNT_W-1:0] cnt_q;

    assign cnt_inc[0] = advance && loaduse;
    assign cnt_inc[1] = advance && mispred;
    assign cnt_inc[2] = advance && ret_h && !loaduse;

    genvar g;
    generate
        for (g = 0; g < NCNT; g++) begin : g_cnt
            pipe_ctrl_satcnt #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[g]),
                .cnt (cnt_q[g])
            );
        end
    endgenerate

    assign loaduse_cnt = cnt_q[0];
    assign mispred_cnt = cnt_q[1];
    assign ret_cnt     = cnt_q[2];
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: spec-level model checked every negedge plus directed literal checks.
module tb_pipe_ctrl;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, m_stat, W_stat;
    logic e_Cnd, step_mode, step_pulse;
    logic F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [3:0] cpu_stat;
    logic [CW-1:0] loaduse_cnt, mispred_cnt, ret_cnt;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .m_stat(m_stat),
        .W_stat(W_stat), .step_mode(step_mode), .step_pulse(step_pulse),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
        .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
        .loaduse_cnt(loaduse_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: processor mode and counter values as plain integers
    bit m_stopped, m_paused;
    int m_stat_q, m_lu, m_mp, m_rt;

    function automatic bit f_lu();
        return (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic bit f_mp();
        return E_icode == 7 && !e_Cnd;
    endfunction
    function automatic bit f_rt();
        return D_icode == 9 || E_icode == 9 || M_icode == 9;
    endfunction
    function automatic bit f_bad(input logic [3:0] s);
        return s == 2 || s == 3 || s == 4;
    endfunction
    function automatic bit f_adv();
        return !m_stopped && (!m_paused || step_pulse);
    endfunction
    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_stopped = 0; m_paused = 0; m_stat_q = 1; m_lu = 0; m_mp = 0; m_rt = 0;
        end else begin
            if (f_adv()) begin
                if (f_lu()) m_lu = sat_inc(m_lu);
                if (f_mp()) m_mp = sat_inc(m_mp);
                if (f_rt() && !f_lu()) m_rt = sat_inc(m_rt);
            end
            if (f_adv() && W_stat != 1) begin
                m_stopped = 1; m_paused = 0; m_stat_q = W_stat;
            end
`ifdef PIPE_CTRL_STEP_EN
            else if (!m_stopped) m_paused = step_mode;
`endif
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            bit run, lu, mp, rt, ex;
            run = rst || f_adv();
            lu = f_lu(); mp = f_mp(); rt = f_rt(); ex = f_bad(m_stat) || f_bad(W_stat);
            chk("F_stall",  F_stall,  run ? int'(lu || rt) : 1);
            chk("D_stall",  D_stall,  run ? int'(lu) : 1);
            chk("E_stall",  E_stall,  run ? 0 : 1);
            chk("M_stall",  M_stall,  run ? 0 : 1);
            chk("W_stall",  W_stall,  run ? int'(W_stat != 1) : 1);
            chk("D_bubble", D_bubble, run ? int'(mp || (rt && !lu)) : 0);
            chk("E_bubble", E_bubble, run ? int'(mp || lu) : 0);
            chk("M_bubble", M_bubble, run ? int'(ex) : 0);
            chk("set_cc",   set_cc,   run ? int'(E_icode == 6 && !ex) : 0);
            chk("cpu_stat", cpu_stat, m_stat_q);
            chk("halted",   halted,   m_stopped);
            chk("loaduse_cnt", loaduse_cnt, m_lu);
            chk("mispred_cnt", mispred_cnt, m_mp);
            chk("ret_cnt",     ret_cnt,     m_rt);
        end
    end

    task automatic idle();
        D_icode = 1; E_icode = 1; M_icode = 1; E_dstM = 15; d_srcA = 15; d_srcB = 15;
        e_Cnd = 1; m_stat = 1; W_stat = 1; step_mode = 0; step_pulse = 0;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        rst = 1; idle();
        tick();
        model_en = 1;
        rst = 0; #1;
        chk("rst cpu_stat", cpu_stat, 1);
        chk("rst halted", halted, 0);
        chk("rst loaduse_cnt", loaduse_cnt, 0);
        chk("rst F_stall", F_stall, 0);

        // Load-use
        E_icode = 5; E_dstM = 3; d_srcA = 3; #1;
        chk("lu F_stall", F_stall, 1); chk("lu D_stall", D_stall, 1);
        chk("lu E_bubble", E_bubble, 1); chk("lu D_bubble", D_bubble, 0);
        tick(); idle(); #1;
        chk("lu cnt", loaduse_cnt, 1);

        // Ret travelling D -> E -> M
        D_icode = 9; #1;
        chk("ret F_stall", F_stall, 1); chk("ret D_bubble", D_bubble, 1);
        tick(); D_icode = 1; E_icode = 9;
        tick(); E_icode = 1; M_icode = 9;
        tick(); idle(); #1;
        chk("ret cnt", ret_cnt, 3);

        // Mispredict with ret in D
        E_icode = 7; e_Cnd = 0; D_icode = 9; #1;
        chk("mp D_bubble", D_bubble, 1); chk("mp E_bubble", E_bubble, 1); chk("mp F_stall", F_stall, 1);
        tick(); idle(); #1;
        chk("mp cnt", mispred_cnt, 1); chk("mp ret cnt", ret_cnt, 4);

        // Exception, halt, sticky stop, reset recovery
        m_stat = 3; E_icode = 6; #1;
        chk("exc M_bubble", M_bubble, 1); chk("exc set_cc", set_cc, 0);
        tick(); m_stat = 1; E_icode = 1; W_stat = 3; #1;
        chk("exc W_stall", W_stall, 1); chk("exc halted pre", halted, 0);
        tick(); W_stat = 1; E_icode = 5; E_dstM = 3; d_srcA = 3; step_pulse = 1; #1;
        chk("stop halted", halted, 1); chk("stop cpu_stat", cpu_stat, 3);
        chk("stop F_stall", F_stall, 1); chk("stop E_stall", E_stall, 1); chk("stop W_stall", W_stall, 1);
        chk("stop E_bubble", E_bubble, 0);
        tick(); #1;
        chk("stop lu frozen", loaduse_cnt, 1);
        idle(); rst = 1; #1;
        chk("rst cycle F_stall", F_stall, 0);
        tick(); rst = 0; #1;
        chk("post rst halted", halted, 0); chk("post rst cpu_stat", cpu_stat, 1);
        chk("post rst ret_cnt", ret_cnt, 0);

        // Saturation
        E_icode = 11; E_dstM = 4; d_srcB = 4;
        for (int i = 0; i < 20; i++) tick();
        #1; chk("sat lu cnt", loaduse_cnt, 15);
        idle(); do_reset();

`ifdef PIPE_CTRL_STEP_EN
        step_mode = 1; #1;
        chk("step run E_stall", E_stall, 0);
        tick(); E_icode = 5; E_dstM = 3; d_srcA = 3; #1;
        chk("pause F_stall", F_stall, 1); chk("pause E_stall", E_stall, 1);
        chk("pause E_bubble", E_bubble, 0);
        tick(); #1; chk("pause cnt frozen", loaduse_cnt, 0);
        step_pulse = 1; #1;
        chk("pulse E_stall", E_stall, 0); chk("pulse E_bubble", E_bubble, 1);
        tick(); step_pulse = 0; #1;
        chk("after pulse E_stall", E_stall, 1); chk("pulse cnt", loaduse_cnt, 1);
        step_mode = 0; #1;
        chk("leave pause same cycle", E_stall, 1);
        tick(); #1;
        chk("resume E_stall", E_stall, 0);
`else
        step_mode = 1; E_icode = 5; E_dstM = 3; d_srcA = 3;
        tick(); tick(); #1;
        chk("nostep E_stall", E_stall, 0); chk("nostep cnt", loaduse_cnt, 2);
`endif
        idle(); tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
